// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake, main + skid entry, synchronous flush.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
`timescale 1ns/1ps
module pipe_stage_elastic #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]    NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // Encoding is {S.valid, M.valid}; outputs decode straight from the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              xfer_in, xfer_out;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (xfer_in) state_nxt = FULL;
        FULL: begin
          if (xfer_in && !xfer_out)      state_nxt = SKID;
          else if (!xfer_in && xfer_out) state_nxt = EMPTY;
        end
        SKID:    if (xfer_out) state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != SKID);
    out_ctrl  = out_valid ? m_ctrl : NOP_CTRL;
    out_data  = m_data;
  end

  // Flush suppresses all loads so out_data stays stable while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl <= '0;
      m_data <= '0;
      s_ctrl <= '0;
      s_data <= '0;
    end else if (!flush) begin
      if ((state == EMPTY && xfer_in) || (state == FULL && xfer_in && xfer_out)) begin
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end else if (state == SKID && xfer_out) begin
        m_ctrl <= s_ctrl;
        m_data <= s_data;
      end
      if (state == FULL && xfer_in && !xfer_out) begin
        s_ctrl <= in_ctrl;
        s_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (stall counter checks under PIPE_STAGE_PERF_EN).
`timescale 1ns/1ps
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [15:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(16), .CTRL_W(8), .NOP_CTRL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_ctrl  = 8'h00;
    in_data  = 16'h0000;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_ctrl !== 8'h00) begin failures++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
`ifdef PIPE_STAGE_PERF_EN
    checks++; if (stall_cnt !== 16'h0000) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0000", stall_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 16'h1234; in_ctrl = 8'h5A; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL single_data got=%h exp=1234", out_data); end
    checks++; if (out_ctrl !== 8'h5A) begin failures++; $display("FAIL single_ctrl got=%h exp=5a", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin failures++; $display("FAIL single_drain_ctrl got=%h exp=00", out_ctrl); end
    checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL single_drain_data_stable got=%h exp=1234", out_data); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      in_ctrl  = 8'(8'h10 + i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i) || out_ctrl !== 8'(8'h10 + i) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d got v=%b d=%h c=%h r=%b exp v=1 d=%h c=%h r=1",
                 i, out_valid, out_data, out_ctrl, in_ready, 16'(i), 8'(8'h10 + i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic fill_skid(input logic [15:0] a, input logic [15:0] b);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a; in_ctrl = 8'hA1;
    step();
    in_data = b; in_ctrl = 8'hB2;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_skid();
    fill_skid(16'hAAAA, 16'hBBBB);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hAAAA || out_ctrl !== 8'hA1) begin
      failures++; $display("FAIL skid_hold_a got v=%b d=%h c=%h exp v=1 d=aaaa c=a1", out_valid, out_data, out_ctrl); end
    // upstream presenting while not ready must be ignored
    in_valid = 1'b1; in_data = 16'hDDDD; in_ctrl = 8'hDD;
    step(); step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_data !== 16'hAAAA) begin
      failures++; $display("FAIL skid_stall_stable got r=%b d=%h exp r=0 d=aaaa", in_ready, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hBBBB || out_ctrl !== 8'hB2) begin
      failures++; $display("FAIL skid_emit_b got v=%b d=%h c=%h exp v=1 d=bbbb c=b2", out_valid, out_data, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_drained got v=%b d=%h exp v=0", out_valid, out_data); end
  endtask

  task automatic test_flush();
    fill_skid(16'h1111, 16'h2222);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hCCCC; in_ctrl = 8'hCC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_skid got v=%b c=%h r=%b exp v=0 c=00 r=1", out_valid, out_ctrl, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c_%0d got v=%b d=%h exp v=0", i, out_valid, out_data); end
    end
    // flush from FULL while an input would otherwise be accepted
    in_valid = 1'b1; in_data = 16'h3333; in_ctrl = 8'h33; out_ready = 1'b0;
    step();
    flush = 1'b1; in_data = 16'h4444; in_ctrl = 8'h44;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_full got v=%b c=%h r=%b exp v=0 c=00 r=1", out_valid, out_ctrl, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_discard got v=%b d=%h exp v=0", out_valid, out_data); end
  endtask

  task automatic test_async_reset();
    fill_skid(16'h5555, 16'h6666);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 8'h00 || out_data !== 16'h0000) begin
      failures++; $display("FAIL async_reset got v=%b r=%b c=%h d=%h exp v=0 r=1 c=00 d=0000", out_valid, in_ready, out_ctrl, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_lost got v=%b exp=0", out_valid); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h7777; in_ctrl = 8'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL stall_cnt_5 got=%0d exp=5", stall_cnt); end
    for (int i = 0; i < 70000; i++) step();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_cnt_sat got=%h exp=ffff", stall_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_cnt_hold got=%h exp=ffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skid();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
